// File: rtl/data_mem_unit.sv
// Memory-stage data memory responder: word-addressed RAM with configurable wait states,
// byte/halfword/word stores, sign/zero-extended loads, and error reporting on mem_done.
module data_mem_unit #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ex_valid,
    input  logic        ex_is_load,
    input  logic        ex_is_store,
    input  logic [2:0]  ex_load_type,
    input  logic [2:0]  ex_store_type,
    input  logic [31:0] ex_addr,
    input  logic [31:0] ex_store_data,
    output logic [31:0] mem_rdata,
    output logic        mem_done,
    output logic        mem_busy,
    output logic        mem_misaligned,
    output logic        mem_fault
);
    localparam int         AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t     state, state_nx;
    logic [3:0] cnt, cnt_nx;

    logic          req_load;
    logic [2:0]    req_type;
    logic [AW+1:0] req_addr;
    logic [31:0]   req_data;

    logic [31:0] ram [DEPTH_WORDS];

    // Decode and error classification on the live request (only meaningful in IDLE).
    logic       accept, is_both, type_bad, misaligned, out_of_range;
    logic       err_fault, err_mis, err_any;
    logic [2:0] in_type;

    always_comb begin
        accept  = (state == IDLE) && ex_valid && (ex_is_load || ex_is_store);
        is_both = ex_is_load && ex_is_store;
        in_type = ex_is_load ? ex_load_type : ex_store_type;
        if (ex_is_load)
            type_bad = (ex_load_type == 3'b011) || (ex_load_type[2:1] == 2'b11);
        else
            type_bad = ex_store_type[2] || (ex_store_type[1:0] == 2'b11);
        misaligned   = ((in_type[1:0] == 2'b01) && ex_addr[0]) ||
                       ((in_type[1:0] == 2'b10) && (ex_addr[1:0] != 2'b00));
        out_of_range = {2'b00, ex_addr[31:2]} >= 32'(DEPTH_WORDS);
        err_fault    = is_both || type_bad || (!misaligned && out_of_range);
        err_mis      = !is_both && !type_bad && misaligned;
        err_any      = err_fault || err_mis;
    end

    // With zero wait states the access uses the live request on the accept edge;
    // otherwise it uses the copy captured at accept.
    logic          acc_load, do_access;
    logic [2:0]    acc_type;
    logic [AW+1:0] acc_addr;
    logic [31:0]   acc_data, word, ld_val, wr_data;
    logic [3:0]    wr_be;
    logic [7:0]    ld_byte;
    logic [15:0]   ld_half;

    always_comb begin
        if (state == IDLE) begin
            acc_load = ex_is_load;
            acc_type = in_type;
            acc_addr = ex_addr[AW+1:0];
            acc_data = ex_store_data;
        end else begin
            acc_load = req_load;
            acc_type = req_type;
            acc_addr = req_addr;
            acc_data = req_data;
        end
        do_access = (state == IDLE) ? (accept && !err_any && (WAIT_STATES == 0))
                                    : ((state == WAIT) && (cnt == 4'd0));

        word    = ram[acc_addr[AW+1:2]];
        ld_byte = word[{acc_addr[1:0], 3'b000} +: 8];
        ld_half = acc_addr[1] ? word[31:16] : word[15:0];
        case (acc_type)
            3'b000:  ld_val = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_val = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_val = {24'd0, ld_byte};
            3'b101:  ld_val = {16'd0, ld_half};
            default: ld_val = word;
        endcase

        case (acc_type[1:0])
            2'b00: begin
                wr_data = {4{acc_data[7:0]}};
                wr_be   = 4'b0001 << acc_addr[1:0];
            end
            2'b01: begin
                wr_data = {2{acc_data[15:0]}};
                wr_be   = acc_addr[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                wr_data = acc_data;
                wr_be   = 4'b1111;
            end
        endcase
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        mem_busy = 1'b0;
        case (state)
            IDLE: if (accept) begin
                mem_busy = 1'b1;
                if (err_any || (WAIT_STATES == 0)) begin
                    state_nx = RESP;
                end else begin
                    state_nx = WAIT;
                    cnt_nx   = WAIT_LOAD;
                end
            end
            WAIT: begin
                mem_busy = 1'b1;
                if (cnt == 4'd0) state_nx = RESP;
                else             cnt_nx   = cnt - 4'd1;
            end
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            cnt            <= 4'd0;
            mem_done       <= 1'b0;
            mem_misaligned <= 1'b0;
            mem_fault      <= 1'b0;
            mem_rdata      <= 32'd0;
        end else begin
            state          <= state_nx;
            cnt            <= cnt_nx;
            mem_done       <= (state_nx == RESP);
            mem_misaligned <= accept && err_mis;
            mem_fault      <= accept && err_fault;
            if (accept && err_any)
                mem_rdata <= 32'd0;
            else if (do_access)
                mem_rdata <= acc_load ? ld_val : 32'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            req_load <= ex_is_load;
            req_type <= in_type;
            req_addr <= ex_addr[AW+1:0];
            req_data <= ex_store_data;
        end
    end

    // Reset on the commit edge suppresses the pending store.
    always_ff @(posedge clk) begin
        if (!reset && do_access && !acc_load) begin
            for (int i = 0; i < 4; i++)
                if (wr_be[i]) ram[acc_addr[AW+1:2]][8*i +: 8] <= wr_data[8*i +: 8];
        end
    end
endmodule

// File: tb/tb_data_mem_unit.sv
// Bench for data_mem_unit: three instances (0, 1, 3 wait states) checked against a byte-level
// memory model with directed cases followed by randomized request streams.
module tb_data_mem_unit;
    localparam int N = 3;

    typedef struct packed {
        logic        isl;
        logic        iss;
        logic [2:0]  lt;
        logic [2:0]  st;
        logic [31:0] a;
        logic [31:0] d;
    } req_t;

    logic clk = 1'b0;
    logic reset;
    logic [N-1:0]       valid, isl, iss, done, busy, mis, flt;
    logic [N-1:0][2:0]  lt, st;
    logic [N-1:0][31:0] addr, sdata, rdata;

    int checks = 0;
    int errors = 0;
    int wait_of [N] = '{0, 1, 3};
    logic [31:0] last [N];
    bit [7:0] mdl [longint];

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        data_mem_unit #(
            .DEPTH_WORDS(1024),
            .WAIT_STATES(g == 0 ? 0 : (g == 1 ? 1 : 3))
        ) dut (
            .clk(clk), .reset(reset),
            .ex_valid(valid[g]), .ex_is_load(isl[g]), .ex_is_store(iss[g]),
            .ex_load_type(lt[g]), .ex_store_type(st[g]),
            .ex_addr(addr[g]), .ex_store_data(sdata[g]),
            .mem_rdata(rdata[g]), .mem_done(done[g]), .mem_busy(busy[g]),
            .mem_misaligned(mis[g]), .mem_fault(flt[g])
        );
    end

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic longint key(int k, logic [31:0] a);
        return {k, a};
    endfunction

    // Reference: error classification, load value and store side effect on a byte map.
    function automatic void model(int k, req_t r, output bit f, output bit m, output logic [31:0] v);
        int n;
        logic [2:0] t;
        bit ok;
        t  = r.isl ? r.lt : r.st;
        ok = r.isl ? (r.lt inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (r.st inside {3'd0, 3'd1, 3'd2});
        n  = (t[1:0] == 2'd0) ? 1 : (t[1:0] == 2'd1) ? 2 : 4;
        f = 0; m = 0; v = 32'd0;
        if ((r.isl && r.iss) || !ok) f = 1;
        else if (r.a % n != 0) m = 1;
        else if (r.a / 4 >= 1024) f = 1;
        else if (r.isl) begin
            for (int i = 0; i < n; i++) v |= 32'(mdl[key(k, r.a + i)]) << (8 * i);
            if (!t[2] && n < 4 && v[8*n-1]) v |= ~((32'd1 << (8 * n)) - 32'd1);
        end else begin
            for (int i = 0; i < n; i++) mdl[key(k, r.a + i)] = 8'(r.d >> (8 * i));
        end
    endfunction

    function automatic req_t mk(bit l, bit s, logic [2:0] t, logic [31:0] a, logic [31:0] d);
        req_t r;
        r.isl = l; r.iss = s; r.lt = t; r.st = t; r.a = a; r.d = d;
        return r;
    endfunction

    function automatic req_t rnd();
        req_t r;
        logic [2:0] lts [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        int sel = $urandom_range(0, 19);
        r.isl = (sel <= 10);
        r.iss = (sel == 0) || (sel > 10);
        r.lt  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : lts[$urandom_range(0, 4)];
        r.st  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 2));
        r.a   = 32'($urandom_range(0, 63));
        if ($urandom_range(0, 3) != 0) r.a = r.a & ~32'd3;
        if ($urandom_range(0, 11) == 0) r.a = r.a | 32'h1000 | ($urandom & 32'hFFFF_0000);
        r.d   = $urandom;
        return r;
    endfunction

    task automatic drive(int k, logic v, req_t r);
        valid[k] = v; isl[k] = r.isl; iss[k] = r.iss; lt[k] = r.lt; st[k] = r.st;
        addr[k] = r.a; sdata[k] = r.d;
    endtask

    task automatic scramble(int k, logic v);
        req_t g;
        g.isl = 1'($urandom_range(0, 1)); g.iss = 1'($urandom_range(0, 1));
        g.lt = 3'($urandom_range(0, 7)); g.st = 3'($urandom_range(0, 7));
        g.a = $urandom; g.d = $urandom;
        drive(k, v, g);
    endtask

    // One request from accept (cycle 0) through its mem_done cycle; optionally presents
    // the next request already in the response cycle.
    task automatic run(int k, req_t r, bit early, req_t nx, output logic [31:0] got);
        bit f, m;
        logic [31:0] v;
        int lat;
        model(k, r, f, m, v);
        lat = (f || m) ? 1 : wait_of[k] + 1;
        got = 32'hx;
        @(posedge clk); #1;
        drive(k, 1'b1, r);
        for (int c = 0; c <= lat; c++) begin
            if (c > 0) begin
                @(posedge clk); #1;
                if (c == lat) begin
                    if (early) drive(k, 1'b1, nx);
                    else       scramble(k, 1'b0);
                end else scramble(k, 1'($urandom_range(0, 1)));
            end
            @(negedge clk);
            chk($sformatf("busy k%0d c%0d", k, c), 32'(busy[k]),
                32'((c == 0) || (!(f || m) && c < lat)));
            chk($sformatf("done k%0d c%0d", k, c), 32'(done[k]), 32'(c == lat));
            if (c == 0) begin
                chk($sformatf("rdata_hold k%0d", k), rdata[k], last[k]);
                chk($sformatf("flags_idle k%0d", k), {30'd0, mis[k], flt[k]}, 32'd0);
            end
            if (c == lat) begin
                chk($sformatf("rdata k%0d a%h", k, r.a), rdata[k], v);
                chk($sformatf("misaligned k%0d a%h", k, r.a), 32'(mis[k]), 32'(m));
                chk($sformatf("fault k%0d a%h", k, r.a), 32'(flt[k]), 32'(f));
                last[k] = v;
                got = rdata[k];
            end
        end
    endtask

    initial begin
        logic [31:0] got;
        req_t cur, nx, z;
        z = mk(0, 0, 3'd0, 32'd0, 32'd0);
        reset = 1'b1;
        for (int k = 0; k < N; k++) begin
            drive(k, 1'b0, z);
            last[k] = 32'd0;
        end
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        for (int k = 0; k < N; k++)
            chk($sformatf("reset_outs k%0d", k),
                {rdata[k] | {28'd0, done[k], busy[k], mis[k], flt[k]}}, 32'd0);

        // Directed sequence on the single-wait-state instance.
        run(1, mk(0, 1, 3'd2, 32'h10, 32'hDEADBEEF), 0, z, got);
        run(1, mk(1, 0, 3'd2, 32'h10, 32'd0), 0, z, got); chk("lw10", got, 32'hDEADBEEF);
        run(1, mk(1, 0, 3'd0, 32'h13, 32'd0), 0, z, got); chk("lb13", got, 32'hFFFFFFDE);
        run(1, mk(1, 0, 3'd4, 32'h13, 32'd0), 0, z, got); chk("lbu13", got, 32'h000000DE);
        run(1, mk(1, 0, 3'd1, 32'h10, 32'd0), 0, z, got); chk("lh10", got, 32'hFFFFBEEF);
        run(1, mk(1, 0, 3'd5, 32'h12, 32'd0), 0, z, got); chk("lhu12", got, 32'h0000DEAD);
        run(1, mk(0, 1, 3'd0, 32'h11, 32'h000000AA), 0, z, got);
        run(1, mk(1, 0, 3'd2, 32'h10, 32'd0), 0, z, got); chk("lw_after_sb", got, 32'hDEADAAEF);
        run(1, mk(0, 1, 3'd1, 32'h12, 32'h00001234), 0, z, got);
        run(1, mk(1, 0, 3'd2, 32'h10, 32'd0), 0, z, got); chk("lw_after_sh", got, 32'h1234AAEF);
        run(1, mk(1, 0, 3'd2, 32'h12, 32'd0), 0, z, got); chk("lw_misaligned", got, 32'd0);
        run(1, mk(0, 1, 3'd2, 32'h11, 32'hFFFFFFFF), 0, z, got);
        run(1, mk(1, 0, 3'd2, 32'h10, 32'd0), 0, z, got); chk("lw_unchanged", got, 32'h1234AAEF);
        run(1, mk(1, 0, 3'd2, 32'h1000, 32'd0), 0, z, got); chk("lw_range", got, 32'd0);
        run(1, mk(1, 1, 3'd2, 32'h10, 32'd0), 0, z, got); chk("ld_st_both", got, 32'd0);

        // Ignored requests: no valid, or neither load nor store.
        @(posedge clk); #1 drive(0, 1'b0, mk(1, 0, 3'd2, 32'h0, 32'd0));
        @(negedge clk); chk("ignore_novalid busy", 32'(busy[0]), 32'd0);
        @(posedge clk); #1 drive(0, 1'b1, mk(0, 0, 3'd2, 32'h0, 32'd0));
        @(negedge clk); chk("ignore_noop busy", 32'(busy[0]), 32'd0);
        @(posedge clk); #1 drive(0, 1'b0, z);
        @(negedge clk); chk("ignore done", 32'(done[0]), 32'd0);

        // Store aborted by reset on its commit edge.
        run(1, mk(0, 1, 3'd2, 32'h20, 32'h0), 0, z, got);
        @(posedge clk); #1 drive(1, 1'b1, mk(0, 1, 3'd2, 32'h20, 32'h11111111));
        @(negedge clk); chk("abort busy c0", 32'(busy[1]), 32'd1);
        @(posedge clk); #1 drive(1, 1'b0, z); reset = 1'b1;
        @(negedge clk); chk("abort done c1", 32'(done[1]), 32'd0);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("abort outs", {rdata[1] | {28'd0, done[1], busy[1], mis[1], flt[1]}}, 32'd0);
        for (int k = 0; k < N; k++) last[k] = 32'd0;
        run(1, mk(1, 0, 3'd2, 32'h20, 32'd0), 0, z, got); chk("lw_after_abort", got, 32'd0);

        // Randomized streams with back-to-back issue on every wait-state setting.
        for (int k = 0; k < N; k++) begin
            for (int w = 0; w < 16; w++)
                run(k, mk(0, 1, 3'd2, 32'(w * 4), $urandom), 0, z, got);
            cur = rnd();
            for (int i = 0; i < 40; i++) begin
                nx = rnd();
                run(k, cur, 1'($urandom_range(0, 1)), nx, got);
                cur = nx;
            end
            run(k, cur, 0, z, got);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
